// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register indices and
// the machine word width used by the decode/write-back slice.
package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } regsel_t;

  localparam regsel_t REGSEL_NONE = '{src_a: REG_NONE, src_b: REG_NONE,
                                      dst_e: REG_NONE, dst_m: REG_NONE};

endpackage

// File: rtl/regfile_2r2w.sv
// Y86-64 register file: NREG x 64-bit words, two combinational read ports plus
// a debug peek, two write ports where port M overrides port E on collision.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b,
  input  logic              we_e,
  input  logic [3:0]        waddr_e,
  input  logic [WORD_W-1:0] wdata_e,
  input  logic              we_m,
  input  logic [3:0]        waddr_m,
  input  logic [WORD_W-1:0] wdata_m,
  input  logic [3:0]        dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  logic [WORD_W-1:0] regs_r [NREG];

  // Register storage: async clear, port M takes priority over port E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && (waddr_m == i[3:0])) begin
          regs_r[i] <= wdata_m;
        end else if (we_e && (waddr_e == i[3:0])) begin
          regs_r[i] <= wdata_e;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read port A; index 0xF (and anything past NREG) reads as zero.
  always_comb begin
    rdata_a = '0;
    if ((raddr_a != REG_NONE) && (int'(raddr_a) < NREG)) begin
      rdata_a = regs_r[raddr_a];
    end else begin
      rdata_a = '0;
    end
  end

  // Read port B.
  always_comb begin
    rdata_b = '0;
    if ((raddr_b != REG_NONE) && (int'(raddr_b) < NREG)) begin
      rdata_b = regs_r[raddr_b];
    end else begin
      rdata_b = '0;
    end
  end

  // Debug peek port.
  always_comb begin
    dbg_data = '0;
    if ((dbg_addr != REG_NONE) && (int'(dbg_addr) < NREG)) begin
      dbg_data = regs_r[dbg_addr];
    end else begin
      dbg_data = '0;
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: derives srcA/srcB/dstE/dstM from the
// instruction, reads operands and commits valE/valM into the register file.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valM,
  input  logic              wb_en,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB,
  input  logic [3:0]        dbg_sel,
  output logic [WORD_W-1:0] dbg_val
);

  regsel_t sel_s;
  logic    we_e_s;
  logic    we_m_s;

  // Register specifier decode; unknown icodes neither read nor write.
  always_comb begin
    sel_s = REGSEL_NONE;
    case (icode)
      I_RRMOVQ: begin
        sel_s.src_a = rA;
        if (cnd) begin
          sel_s.dst_e = rB;
        end else begin
          sel_s.dst_e = REG_NONE;
        end
      end
      I_IRMOVQ: begin
        sel_s.dst_e = rB;
      end
      I_RMMOVQ: begin
        sel_s.src_a = rA;
        sel_s.src_b = rB;
      end
      I_MRMOVQ: begin
        sel_s.src_b = rB;
        sel_s.dst_m = rA;
      end
      I_OPQ: begin
        sel_s.src_a = rA;
        sel_s.src_b = rB;
        sel_s.dst_e = rB;
      end
      I_CALL: begin
        sel_s.src_b = REG_RSP;
        sel_s.dst_e = REG_RSP;
      end
      I_RET: begin
        sel_s.src_a = REG_RSP;
        sel_s.src_b = REG_RSP;
        sel_s.dst_e = REG_RSP;
      end
      I_PUSHQ: begin
        sel_s.src_a = rA;
        sel_s.src_b = REG_RSP;
        sel_s.dst_e = REG_RSP;
      end
      I_POPQ: begin
        sel_s.src_a = REG_RSP;
        sel_s.src_b = REG_RSP;
        sel_s.dst_e = REG_RSP;
        sel_s.dst_m = rA;
      end
      default: begin
        sel_s = REGSEL_NONE;
      end
    endcase
  end

  // Write enables: gated by wb_en and suppressed for the "none" index.
  always_comb begin
    we_e_s = 1'b0;
    we_m_s = 1'b0;
    if (wb_en) begin
      we_e_s = (sel_s.dst_e != REG_NONE);
      we_m_s = (sel_s.dst_m != REG_NONE);
    end else begin
      we_e_s = 1'b0;
      we_m_s = 1'b0;
    end
  end

  regfile_2r2w #(
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr_a  (sel_s.src_a),
    .raddr_b  (sel_s.src_b),
    .rdata_a  (valA),
    .rdata_b  (valB),
    .we_e     (we_e_s),
    .waddr_e  (sel_s.dst_e),
    .wdata_e  (valE),
    .we_m     (we_m_s),
    .waddr_m  (sel_s.dst_m),
    .wdata_m  (valM),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_val)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed scoreboard bench for decode_writeback: expected values are queued
// when a step is driven and popped when the matching output is sampled.
module tb_decode_writeback;
  import y86_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q [$];
  logic [63:0] model [15];

  decode_writeback #(.NREG(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .wb_en   (wb_en),
    .valA    (valA),
    .valB    (valB),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic we);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = we;
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, expected value missing from scoreboard", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] s, input logic [63:0] e);
    exp_q.push_back(e);
    dbg_sel = s;
    #1;
    check(tag, dbg_val);
  endtask

  task automatic expect_ab(input string tag, input logic [63:0] ea, input logic [63:0] eb);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    #1;
    check({tag, "_valA"}, valA);
    check({tag, "_valB"}, valB);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Peeks every register against the model with writes disabled.
  task automatic check_all(input string tag);
    wb_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_reg($sformatf("%s_r%0d", tag, i), i[3:0], model[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model[i] = 64'd0;
    rst_n = 1'b1;
    dbg_sel = 4'h0;
    drive(I_NOP, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_all("rst");
    drive(I_OPQ, 4'h3, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    expect_ab("rst_rd", 64'd0, 64'd0);
    rst_n = 1'b1;

    // Preload R3, then reset between edges.
    drive(I_IRMOVQ, 4'hF, 4'h3, 1'b0, 64'd5, 64'd0, 1'b1);
    step();
    expect_reg("preload_r3", 4'h3, 64'd5);
    rst_n = 1'b0;
    expect_reg("async_clr_r3", 4'h3, 64'd0);
    drive(I_RRMOVQ, 4'h3, 4'h7, 1'b0, 64'd0, 64'd0, 1'b0);
    expect_ab("async_clr_rd", 64'd0, 64'd0);
    drive(I_IRMOVQ, 4'hF, 4'h3, 1'b0, 64'h77, 64'd0, 1'b1);
    step();
    expect_reg("wr_in_reset", 4'h3, 64'd0);
    rst_n = 1'b1;
    step();
    model[3] = 64'h77;
    expect_reg("first_wr", 4'h3, 64'h77);

    // irmovq then OPq read; OPq write has no bypass into its own read.
    drive(I_IRMOVQ, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0, 1'b1);
    step();
    model[2] = 64'h1234;
    drive(I_OPQ, 4'h2, 4'h2, 1'b0, 64'h9, 64'd0, 1'b1);
    expect_ab("opq_rd", 64'h1234, 64'h1234);
    step();
    model[2] = 64'h9;
    expect_reg("opq_wr", 4'h2, 64'h9);

    // cmovXX gated by cnd.
    drive(I_RRMOVQ, 4'h1, 4'h5, 1'b0, 64'd7, 64'd0, 1'b1);
    step();
    expect_reg("cmov_nc", 4'h5, 64'd0);
    drive(I_RRMOVQ, 4'h1, 4'h5, 1'b1, 64'd7, 64'd0, 1'b1);
    step();
    model[5] = 64'd7;
    expect_reg("cmov_c", 4'h5, 64'd7);

    // popq %rsp: valM wins over valE.
    drive(I_IRMOVQ, 4'hF, 4'h4, 1'b0, 64'h100, 64'd0, 1'b1);
    step();
    model[4] = 64'h100;
    drive(I_POPQ, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 1'b1);
    expect_ab("popq_rsp_rd", 64'h100, 64'h100);
    step();
    model[4] = 64'hBEEF;
    expect_reg("popq_rsp_wr", 4'h4, 64'hBEEF);

    // popq %rsi: dual write in one edge.
    drive(I_POPQ, 4'h6, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    step();
    model[4] = 64'h108;
    model[6] = 64'h55;
    expect_reg("popq_r4", 4'h4, 64'h108);
    expect_reg("popq_r6", 4'h6, 64'h55);

    // call, mrmovq, rmmovq operand selection.
    drive(I_CALL, 4'h3, 4'h3, 1'b0, 64'h100, 64'd0, 1'b1);
    expect_ab("call_rd", 64'd0, 64'h108);
    step();
    model[4] = 64'h100;
    drive(I_MRMOVQ, 4'h8, 4'h4, 1'b0, 64'h999, 64'hCAFE, 1'b1);
    expect_ab("mr_rd", 64'd0, 64'h100);
    step();
    model[8] = 64'hCAFE;
    expect_reg("mr_wr", 4'h8, 64'hCAFE);
    drive(I_RMMOVQ, 4'h8, 4'h6, 1'b0, 64'hAAAA, 64'hBBBB, 1'b1);
    expect_ab("rm_rd", 64'hCAFE, 64'h55);
    step();
    drive(I_PUSHQ, 4'h2, 4'hF, 1'b0, 64'hF8, 64'd0, 1'b1);
    expect_ab("push_rd", 64'h9, 64'h100);
    step();
    model[4] = 64'hF8;
    check_all("ops");

    // Writes with wb_en=0 are ignored.
    drive(I_IRMOVQ, 4'hF, 4'h7, 1'b0, 64'hDEAD, 64'hBEEF, 1'b0);
    step();
    drive(I_POPQ, 4'h9, 4'hF, 1'b0, 64'h1, 64'h2, 1'b0);
    step();
    check_all("wb_off");

    // nop, unknown icode and a write to index 0xF change nothing.
    drive(I_NOP, 4'h0, 4'h0, 1'b1, 64'h1111, 64'h2222, 1'b1);
    expect_ab("nop_rd", 64'd0, 64'd0);
    step();
    drive(4'hC, 4'h0, 4'h1, 1'b1, 64'h3333, 64'h4444, 1'b1);
    expect_ab("unk_rd", 64'd0, 64'd0);
    step();
    drive(I_IRMOVQ, 4'hF, 4'hF, 1'b0, 64'h5555, 64'd0, 1'b1);
    step();
    expect_reg("dbg_f", 4'hF, 64'd0);
    check_all("nop_unk");

    if (exp_q.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
